voter_registry: RTL and testbench

- Parametrised voter-status store for the EVM. Successor to the single-entry voter memory; it tracks a "has voted" flag for every enrolled voter.
- Accepts vote-authorisation requests, rejects duplicate, out-of-range and closed-election requests, and keeps a running turnout count.
- Sits between the voter-ID entry logic and the ballot/tally unit. The tally unit only counts a ballot after this block returns status OK.

---
 rtl/voter_registry_if.sv | 32 +++
 rtl/voter_registry.sv | 110 +++++++++++
 tb/tb_voter_registry.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/voter_registry_if.sv
// Bus between the voter-ID entry logic and the voter registry: request/clear/query
// inputs plus the result strobe, status and turnout outputs.
interface voter_registry_if #(
    parameter int ID_W  = 4,
    parameter int CNT_W = 4
);
    logic             election_open;
    logic             vote_req;
    logic [ID_W-1:0]  voter_id;
    logic             clear_all;
    logic [ID_W-1:0]  query_id;
    logic             query_voted;
    logic             busy;
    logic             result_valid;
    logic [1:0]       result_code;
    logic [CNT_W-1:0] voted_count;
    logic             all_voted;
    logic [1:0]       fsm_state;

    // Handshake: vote_req is a one-cycle strobe honoured only while busy = 0;
    // exactly one result_valid pulse answers each accepted request, and
    // result_code is meaningful only during that pulse.
    modport master (
        output election_open, vote_req, voter_id, clear_all, query_id,
        input  query_voted, busy, result_valid, result_code, voted_count, all_voted, fsm_state
    );

    modport slave (
        input  election_open, vote_req, voter_id, clear_all, query_id,
        output query_voted, busy, result_valid, result_code, voted_count, all_voted, fsm_state
    );
endinterface

// File: rtl/voter_registry.sv
// Per-voter "has voted" store: authorises each voter at most once per session,
// rejects duplicate/out-of-range/closed requests and tracks turnout.
module voter_registry #(
    parameter int ID_W       = 4,
    parameter int NUM_VOTERS = 10,
    parameter int CNT_W      = $clog2(NUM_VOTERS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    voter_registry_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] CODE_OK        = 2'b00;
    localparam logic [1:0] CODE_DUPLICATE = 2'b01;
    localparam logic [1:0] CODE_RANGE     = 2'b10;
    localparam logic [1:0] CODE_CLOSED    = 2'b11;

    localparam int NUM_SLOTS = 1 << ID_W;
    localparam logic [ID_W:0]    ID_LIMIT = (ID_W + 1)'(NUM_VOTERS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VOTERS);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  req_id;
    logic             req_open;
    logic [1:0]       code_q;
    logic [1:0]       lookup_code;
    logic             accept;
    logic             commit_ok;
    logic             clear_ok;
    // Sized to the full ID space so any id can index safely; slots at or
    // above NUM_VOTERS are never written and read back as 0.
    logic [NUM_SLOTS-1:0] flags;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic             all_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        lookup_code = CODE_OK;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.vote_req) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!req_open)                   lookup_code = CODE_CLOSED;
                else if ({1'b0, req_id} >= ID_LIMIT) lookup_code = CODE_RANGE;
                else if (flags[req_id])          lookup_code = CODE_DUPLICATE;
                else                             lookup_code = CODE_OK;
                state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A clear competing with a request loses; the request is served instead.
    assign clear_ok  = (state == IDLE) && !bus.election_open && !bus.vote_req && bus.clear_all;
    assign commit_ok = (state == COMMIT) && (code_q == CODE_OK);
    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_id   <= '0;
            req_open <= 1'b0;
            code_q   <= CODE_OK;
            flags    <= '0;
            count_q  <= '0;
            all_q    <= 1'b0;
        end else begin
            if (accept) begin
                req_id   <= bus.voter_id;
                req_open <= bus.election_open;
            end
            if (state == LOOKUP) code_q <= lookup_code;
            if (commit_ok) begin
                flags[req_id] <= 1'b1;
                if (count_q != CNT_MAX) begin
                    count_q <= count_inc;
                    all_q   <= (count_inc == CNT_MAX);
                end
            end else if (clear_ok) begin
                flags   <= '0;
                count_q <= '0;
                all_q   <= 1'b0;
            end
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == COMMIT);
    assign bus.result_code  = code_q;
    assign bus.voted_count  = count_q;
    assign bus.all_voted    = all_q;
    assign bus.query_voted  = ({1'b0, bus.query_id} < ID_LIMIT) && flags[bus.query_id];
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_voter_registry.sv
// Directed bench for voter_registry: stimulus tasks push expected result codes,
// a negedge monitor pops and compares them whenever result_valid is seen.
module tb_voter_registry;
    localparam int ID_W       = 4;
    localparam int NUM_VOTERS = 10;
    localparam int CNT_W      = 4;

    localparam logic [1:0] OK   = 2'b00;
    localparam logic [1:0] DUP  = 2'b01;
    localparam logic [1:0] OOR  = 2'b10;
    localparam logic [1:0] CLSD = 2'b11;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [1:0] exp_q[$];

    voter_registry_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    voter_registry #(.ID_W(ID_W), .NUM_VOTERS(NUM_VOTERS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && bus.result_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got code %0d, expected no response", bus.result_code);
            end else begin
                check("result_code", 32'(bus.result_code), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still 1, expected 0 within 10 cycles", name);
        end
    endtask

    // flip_open toggles election_open right after acceptance; it must not matter.
    task automatic do_vote(input logic [ID_W-1:0] id, input logic open,
                           input logic [1:0] exp, input logic flip_open);
        @(negedge clk);
        bus.election_open = open;
        bus.voter_id      = id;
        bus.vote_req      = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.vote_req = 1'b0;
        if (flip_open) bus.election_open = ~open;
        wait_idle("vote");
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_all = 1'b1;
        @(negedge clk);
        bus.clear_all = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_query(input logic [ID_W-1:0] id, input logic exp);
        bus.query_id = id;
        #1;
        check($sformatf("query_voted[%0d]", id), 32'(bus.query_voted), 32'(exp));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.election_open = 1'b0;
        bus.vote_req      = 1'b0;
        bus.voter_id      = '0;
        bus.clear_all     = 1'b0;
        bus.query_id      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_result_valid", 32'(bus.result_valid), 0);
        check("reset_result_code", 32'(bus.result_code), 0);
        check("reset_count", 32'(bus.voted_count), 0);
        check("reset_all_voted", 32'(bus.all_voted), 0);
        check_query(3, 1'b0);

        // first vote, then duplicate
        do_vote(3, 1'b1, OK, 1'b0);
        check("count_after_3", 32'(bus.voted_count), 1);
        check_query(3, 1'b1);
        do_vote(3, 1'b1, DUP, 1'b0);
        check("count_after_dup", 32'(bus.voted_count), 1);

        // out of range and closed
        do_vote(12, 1'b1, OOR, 1'b0);
        do_vote(5, 1'b0, CLSD, 1'b0);
        check("count_after_rejects", 32'(bus.voted_count), 1);
        check_query(5, 1'b0);
        check_query(12, 1'b0);

        // request while busy is ignored
        @(negedge clk);
        bus.election_open = 1'b1;
        bus.voter_id      = 0;
        bus.vote_req      = 1'b1;
        exp_q.push_back(OK);
        @(negedge clk);
        check("busy_in_lookup", 32'(bus.busy), 1);
        bus.voter_id = 4;
        @(negedge clk);
        check("busy_in_commit", 32'(bus.busy), 1);
        @(negedge clk);
        bus.vote_req = 1'b0;
        check("busy_back_low", 32'(bus.busy), 0);
        repeat (4) @(negedge clk);
        check_query(4, 1'b0);
        check_query(0, 1'b1);
        check("count_after_busy", 32'(bus.voted_count), 2);

        // election closing mid-request does not affect it
        do_vote(8, 1'b1, OK, 1'b1);
        check("count_after_flip", 32'(bus.voted_count), 3);

        // clear only while closed
        bus.election_open = 1'b1;
        pulse_clear();
        check("clear_while_open", 32'(bus.voted_count), 3);
        bus.election_open = 1'b0;
        pulse_clear();
        check("clear_while_closed", 32'(bus.voted_count), 0);
        check_query(3, 1'b0);
        check_query(8, 1'b0);

        // full turnout
        for (int i = 0; i < NUM_VOTERS; i++) begin
            do_vote(ID_W'(i), 1'b1, OK, 1'b0);
            if (i == NUM_VOTERS - 2) check("all_voted_at_9", 32'(bus.all_voted), 0);
        end
        check("count_full", 32'(bus.voted_count), NUM_VOTERS);
        check("all_voted_full", 32'(bus.all_voted), 1);
        do_vote(6, 1'b1, DUP, 1'b0);
        check("count_saturated", 32'(bus.voted_count), NUM_VOTERS);

        // clear together with a request: request wins, clear ignored
        @(negedge clk);
        bus.election_open = 1'b0;
        bus.voter_id      = 2;
        bus.vote_req      = 1'b1;
        bus.clear_all     = 1'b1;
        exp_q.push_back(CLSD);
        @(negedge clk);
        bus.vote_req  = 1'b0;
        bus.clear_all = 1'b0;
        wait_idle("clear_vs_req");
        @(negedge clk);
        check("count_clear_vs_req", 32'(bus.voted_count), NUM_VOTERS);
        pulse_clear();
        check("count_after_clear2", 32'(bus.voted_count), 0);
        check("all_voted_after_clear", 32'(bus.all_voted), 0);

        // reset aborts an in-flight request
        do_vote(1, 1'b1, OK, 1'b0);
        check("count_before_abort", 32'(bus.voted_count), 1);
        @(negedge clk);
        bus.voter_id = 7;
        bus.vote_req = 1'b1;
        @(negedge clk);
        bus.vote_req = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_count", 32'(bus.voted_count), 0);
        check_query(7, 1'b0);
        check_query(1, 1'b0);

        // still functional afterwards
        do_vote(7, 1'b1, OK, 1'b0);
        check_query(7, 1'b1);
        check("count_after_recovery", 32'(bus.voted_count), 1);

        repeat (2) @(negedge clk);
        check("responses_outstanding", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
